countdown_timer: RTL and testbench

Loadable down-counter that complements the team's up-counter. It loads a start value, decrements on prescaled enable ticks, and raises a one-cycle done pulse on expiry. It supports one-shot and auto-reload (periodic) modes, and is used as the timeout and periodic-tick source next to the up-counter in the lab datapath.

---
 rtl/counter_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/countdown_timer.sv | 92 +++++++++
 tb/tb_countdown_timer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the lab counter blocks (up-counter and countdown timer).
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam logic TIMER_ONESHOT = 1'b0;
    localparam logic TIMER_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Prescale counter: emits a one-cycle tick every (presc+1) enabled cycles.
module tick_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] presc,
    output logic          tick
);

    logic [PW-1:0] phase;

    // The tick is combinational so the count update lands on the same edge as the wrap.
    assign tick = en && (phase == presc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            if (tick) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled ticks, one-shot or auto-reload, and a one-cycle done pulse.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [PW-1:0]    presc,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     state, state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_r, reload_next;
    logic [PW-1:0]    presc_r, presc_next;
    logic             mode_r, mode_next;
    logic             done_next;
    logic             presc_en;
    logic             tick;

    // A load restarts the prescale phase, so the prescaler never advances on a load cycle.
    assign presc_en = en && (state == RUN) && !load;

    tick_prescaler #(
        .PW(PW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (presc_en),
        .presc(presc_r),
        .tick (tick)
    );

    assign busy = (state == RUN);

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_r;
        presc_next  = presc_r;
        mode_next   = mode_r;
        done_next   = 1'b0;

        if (load) begin
            reload_next = value;
            count_next  = value;
            presc_next  = presc;
            mode_next   = mode;
            state_next  = (value != '0) ? RUN : IDLE;
        end else if (state == RUN && tick) begin
            // count is at least 1 while running, so the decrement cannot underflow.
            if (count > WIDTH'(1)) begin
                count_next = count - 1'b1;
            end else if (mode_r == TIMER_RELOAD) begin
                count_next = reload_r;
                done_next  = 1'b1;
            end else begin
                count_next = '0;
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            reload_r <= '0;
            presc_r  <= '0;
            mode_r   <= TIMER_ONESHOT;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            reload_r <= reload_next;
            presc_r  <= presc_next;
            mode_r   <= mode_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic against a reference model.
module tb_countdown_timer;

    localparam int WIDTH = 8;
    localparam int PW    = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] value;
    logic [PW-1:0]    presc;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: the timer as "enabled cycles left until the next tick".
    int m_count   = 0;
    int m_reload  = 0;
    int m_presc   = 0;
    int m_mode    = 0;
    int m_left    = 1;
    bit m_running = 0;
    bit m_done    = 0;

    countdown_timer #(
        .WIDTH(WIDTH),
        .PW   (PW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .value(value),
        .presc(presc),
        .mode (mode),
        .count(count),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        m_done = 0;
        if (!rst) begin
            m_count   = 0;
            m_reload  = 0;
            m_presc   = 0;
            m_mode    = 0;
            m_left    = 1;
            m_running = 0;
        end else if (load) begin
            m_reload  = int'(value);
            m_count   = int'(value);
            m_presc   = int'(presc);
            m_mode    = int'(mode);
            m_left    = int'(presc) + 1;
            m_running = (value != 0);
        end else if (m_running && en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_left = m_presc + 1;
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else begin
                    m_done = 1;
                    if (m_mode == 1) begin
                        m_count = m_reload;
                    end else begin
                        m_count   = 0;
                        m_running = 0;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic applyStimulus(input logic rst_v, input logic load_v, input logic en_v,
                                 input int value_v, input int presc_v, input logic mode_v);
        rst   = rst_v;
        load  = load_v;
        en    = en_v;
        value = WIDTH'(value_v);
        presc = PW'(presc_v);
        mode  = mode_v;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("count", int'(count), m_count);
        checkOutput("busy", int'(busy), int'(m_running));
        checkOutput("done", int'(done), int'(m_done));
    endtask

    task automatic runIdle(input logic en_v);
        applyStimulus(1'b1, 1'b0, en_v, 0, 0, 1'b0);
    endtask

    initial begin
        int exp_seq[3];
        int done_seen;
        int enabled;
        int cycles;
        bit finished;
        logic [WIDTH-1:0] rv;

        rst = 1'b0; load = 1'b0; en = 1'b0; value = '0; presc = '0; mode = 1'b0;
        #1;

        $display("[TB] reset with load asserted");
        applyStimulus(1'b0, 1'b1, 1'b1, 9, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 9, 0, 1'b0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_busy", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 9, 0, 1'b0);
        checkOutput("load9_count", int'(count), 9);
        checkOutput("load9_busy", int'(busy), 1);

        $display("[TB] one-shot value=3");
        exp_seq = '{2, 1, 0};
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 0, 1'b0);
        checkOutput("os_load", int'(count), 3);
        for (int i = 0; i < 3; i++) begin
            runIdle(1'b1);
            checkOutput("os_seq", int'(count), exp_seq[i]);
            checkOutput("os_done", int'(done), (i == 2) ? 1 : 0);
        end
        checkOutput("os_busy_fall", int'(busy), 0);
        runIdle(1'b1);
        runIdle(1'b1);
        checkOutput("os_hold0", int'(count), 0);

        $display("[TB] prescale value=2 presc=2");
        applyStimulus(1'b1, 1'b1, 1'b1, 2, 2, 1'b0);
        done_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            runIdle(1'b1);
            if (done) done_seen++;
            if (i == 3) checkOutput("ps_after3", int'(count), 1);
        end
        checkOutput("ps_done_at6", int'(done), 1);
        checkOutput("ps_done_once", done_seen, 1);

        $display("[TB] pause value=4 presc=1");
        applyStimulus(1'b1, 1'b1, 1'b1, 4, 1, 1'b0);
        runIdle(1'b1);
        runIdle(1'b1);
        checkOutput("pz_first_dec", int'(count), 3);
        for (int i = 0; i < 5; i++) runIdle(1'b0);
        checkOutput("pz_frozen", int'(count), 3);
        enabled = 2;
        finished = 0;
        for (int i = 0; i < 20 && !finished; i++) begin
            runIdle(1'b1);
            enabled++;
            if (done) finished = 1;
        end
        checkOutput("pz_finished", int'(finished), 1);
        checkOutput("pz_enabled_cycles", enabled, 8);

        $display("[TB] auto-reload value=4");
        applyStimulus(1'b1, 1'b1, 1'b1, 4, 0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            runIdle(1'b1);
            if (done) done_seen++;
            checkOutput("ar_nonzero", int'(count != 0), 1);
            checkOutput("ar_busy", int'(busy), 1);
        end
        checkOutput("ar_done_pulses", done_seen, 3);

        $display("[TB] load on expiry edge");
        applyStimulus(1'b1, 1'b1, 1'b1, 2, 0, 1'b0);
        runIdle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 5, 0, 1'b0);
        checkOutput("col_count", int'(count), 5);
        checkOutput("col_nodone", int'(done), 0);

        $display("[TB] load zero while running");
        applyStimulus(1'b1, 1'b1, 1'b1, 7, 0, 1'b0);
        runIdle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        checkOutput("z_count", int'(count), 0);
        checkOutput("z_busy", int'(busy), 0);
        checkOutput("z_done", int'(done), 0);

        $display("[TB] full-scale value=255");
        applyStimulus(1'b1, 1'b1, 1'b1, 255, 0, 1'b0);
        cycles = 0;
        finished = 0;
        for (int i = 0; i < 300 && !finished; i++) begin
            runIdle(1'b1);
            cycles++;
            if (done) finished = 1;
        end
        checkOutput("max_finished", int'(finished), 1);
        checkOutput("max_cycles", cycles, 255);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 0, 1'b0);
        runIdle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        checkOutput("mr_done", int'(done), 0);
        checkOutput("mr_count", int'(count), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            rv = WIDTH'($urandom_range(1, 12));
            if ($urandom_range(0, 5) == 0) rv = '0;
            if ($urandom_range(0, 40) == 0) rv = WIDTH'($urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 150) != 0),
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 3) != 0),
                          int'(rv),
                          int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
